// File: rtl/rx_iq_fifo_if.sv
// RX IQ buffer bus: DDC sample input, run control and the rxstream read side.
interface rx_iq_fifo_if #(
    parameter int ADDR_W = 10
);
    logic              run;
    logic [23:0]       iq_i;
    logic [23:0]       iq_q;
    logic              iq_valid;
    logic              rx_request;
    logic [47:0]       rx_data;
    logic [ADDR_W:0]   rx_length;
    logic              overflow;
    logic              underflow;

    // Producer/consumer side (DDC + rxstream)
    modport master (
        output run, iq_i, iq_q, iq_valid, rx_request,
        input  rx_data, rx_length, overflow, underflow
    );

    // FIFO side
    modport slave (
        input  run, iq_i, iq_q, iq_valid, rx_request,
        output rx_data, rx_length, overflow, underflow
    );
endinterface

// File: rtl/rx_iq_fifo.sv
// Single-clock RX IQ sample FIFO: packs {I,Q} into 48-bit words in a circular
// simple dual-port RAM and serves rxstream with a registered read port.
module rx_iq_fifo #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    rx_iq_fifo_if.slave   bus
);
    localparam logic [ADDR_W:0]   LP_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LP_LEN_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W:0]   LP_LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LP_PTR_ZERO = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] LP_PTR_ONE  = ADDR_W'(1);

    logic [47:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_len;
    logic [47:0]       r_rx_data;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic [ADDR_W:0]   w_len_next;

    assign w_empty   = (r_len == LP_LEN_ZERO);
    assign w_full    = (r_len == LP_DEPTH);
    // A read is only refused when empty; a write at full rides on a same-cycle read.
    assign w_rd_acc  = bus.run & bus.rx_request & ~w_empty;
    assign w_wr_acc  = bus.run & bus.iq_valid & (~w_full | w_rd_acc);
    assign w_ovf_set = bus.run & bus.iq_valid & ~w_wr_acc;
    assign w_unf_set = bus.run & bus.rx_request & w_empty;

    // Occupancy update from the accepted write/read pair.
    always_comb begin
        w_len_next = r_len;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_len_next = r_len + LP_LEN_ONE;
            2'b01:   w_len_next = r_len - LP_LEN_ONE;
            default: w_len_next = r_len;
        endcase
    end

    // RAM write port; left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= {bus.iq_i, bus.iq_q};
        end
    end

    // Pointers, occupancy, registered read data and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= LP_PTR_ZERO;
            r_rd_ptr    <= LP_PTR_ZERO;
            r_len       <= LP_LEN_ZERO;
            r_rx_data   <= 48'h0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (!bus.run) begin
            // Flush: rx_data deliberately keeps its last value.
            r_wr_ptr    <= LP_PTR_ZERO;
            r_rd_ptr    <= LP_PTR_ZERO;
            r_len       <= LP_LEN_ZERO;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
            end
            if (w_rd_acc) begin
                // Read-before-write: at full the slot being overwritten is read first.
                r_rx_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + LP_PTR_ONE;
            end
            r_len <= w_len_next;
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_length = r_len;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_rx_iq_fifo.sv
// Randomized self-checking bench for rx_iq_fifo against a queue-based model.
module tb_rx_iq_fifo;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    logic [47:0] m_q [$];
    logic [47:0] m_data;
    logic        m_ovf;
    logic        m_unf;

    rx_iq_fifo_if #(.ADDR_W(10)) bus ();

    rx_iq_fifo #(.DEPTH(DEPTH), .ADDR_W(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_data = 48'h0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".len"}, 64'(bus.rx_length), 64'(m_q.size()));
        chk({tag, ".data"}, 64'(bus.rx_data), 64'(m_data));
        chk({tag, ".ovf"}, 64'(bus.overflow), 64'(m_ovf));
        chk({tag, ".unf"}, 64'(bus.underflow), 64'(m_unf));
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic cyc(input string tag, input logic run, input logic v, input logic req,
                       input logic [23:0] i_s, input logic [23:0] q_s);
        int  sz;
        bit  rd_ok;
        bit  wr_ok;
        bus.run        = run;
        bus.iq_valid   = v;
        bus.rx_request = req;
        bus.iq_i       = i_s;
        bus.iq_q       = q_s;
        @(posedge clk);
        if (!run) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            sz    = m_q.size();
            rd_ok = req && (sz > 0);
            wr_ok = v && ((sz < DEPTH) || rd_ok);
            if (rd_ok) m_data = m_q.pop_front();
            if (wr_ok) m_q.push_back({i_s, q_s});
            if (v && !wr_ok) m_ovf = 1'b1;
            if (req && sz == 0) m_unf = 1'b1;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic wr(input string tag, input logic [23:0] i_s, input logic [23:0] q_s);
        cyc(tag, 1'b1, 1'b1, 1'b0, i_s, q_s);
    endtask

    task automatic rd(input string tag);
        cyc(tag, 1'b1, 1'b0, 1'b1, 24'h0, 24'h0);
    endtask

    initial begin
        logic [23:0] k;
        bus.run        = 1'b0;
        bus.iq_valid   = 1'b0;
        bus.rx_request = 1'b0;
        bus.iq_i       = 24'h0;
        bus.iq_q       = 24'h0;
        reset_n        = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("por");
        reset_n = 1'b1;

        // T1: reset mid-stream, then first read returns first new sample
        for (int n = 0; n < 20; n++) wr("t1w", 24'($urandom), 24'($urandom));
        for (int n = 0; n < 5; n++) rd("t1r");
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all("t1rst");
        @(negedge clk);
        reset_n = 1'b1;
        check_all("t1hold");
        wr("t1new", 24'h123456, 24'hABCDEF);
        rd("t1first");
        chk("t1first_word", 64'(bus.rx_data), 64'h0000_1234_56AB_CDEF);

        // T2: ordering across 172 words
        for (int n = 0; n < 172; n++) begin
            k = 24'(n);
            wr("t2w", k, ~k);
        end
        chk("t2len", 64'(bus.rx_length), 64'd172);
        for (int n = 0; n < 172; n++) begin
            k = 24'(n);
            rd("t2r");
            chk("t2word", 64'(bus.rx_data), 64'({k, ~k}));
        end

        // T3: fill past full
        for (int n = 0; n < 1030; n++) begin
            k = 24'(n);
            wr("t3w", k, 24'h5A5A5A);
        end
        chk("t3len", 64'(bus.rx_length), 64'd1024);
        chk("t3ovf", 64'(bus.overflow), 64'd1);
        for (int n = 0; n < 1024; n++) rd("t3r");
        chk("t3last", 64'(bus.rx_data), 64'({24'd1023, 24'h5A5A5A}));
        rd("t3empty");

        // T4: simultaneous at full and at empty (flush first to clear flags)
        cyc("t4flush", 1'b0, 1'b0, 1'b0, 24'h0, 24'h0);
        for (int n = 0; n < 1024; n++) wr("t4w", 24'($urandom), 24'($urandom));
        cyc("t4full", 1'b1, 1'b1, 1'b1, 24'h777777, 24'h888888);
        chk("t4full_len", 64'(bus.rx_length), 64'd1024);
        chk("t4full_ovf", 64'(bus.overflow), 64'd0);
        for (int n = 0; n < 1024; n++) rd("t4r");
        chk("t4tail", 64'(bus.rx_data), 64'h0000_7777_7788_8888);
        cyc("t4empty", 1'b1, 1'b1, 1'b1, 24'h010203, 24'h040506);
        chk("t4empty_len", 64'(bus.rx_length), 64'd1);
        chk("t4empty_unf", 64'(bus.underflow), 64'd1);
        chk("t4empty_hold", 64'(bus.rx_data), 64'h0000_7777_7788_8888);

        // T5: flush at 500 words
        for (int n = 0; n < 499; n++) wr("t5w", 24'($urandom), 24'($urandom));
        cyc("t5flush", 1'b0, 1'b1, 1'b1, 24'hDEAD00, 24'hBEEF00);
        chk("t5len0", 64'(bus.rx_length), 64'd0);
        wr("t5first", 24'hC0FFEE, 24'h00BABE);
        wr("t5second", 24'h111111, 24'h222222);
        rd("t5r");
        chk("t5word", 64'(bus.rx_data), 64'h0000_C0FF_EE00_BABE);

        // T6: long random stream with read gaps
        for (int n = 0; n < 5000; n++) begin
            cyc("t6", 1'b1, 1'b1, 1'($urandom_range(0, 9) < 8),
                24'($urandom), 24'($urandom));
            chk("t6max", 64'(bus.rx_length <= 11'd1024), 64'd1);
        end
        while (m_q.size() > 0) rd("t6drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
